// File: rtl/axil_regtest_pkg.sv
// rtl/axil_regtest_pkg.sv - state encoding, response codes and watchdog limit for the register test master
package axil_regtest_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      BRESP,
      AR,
      RDATA,
      CHECK,
      NEXT,
      FIN
   } state_t;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_EXOKAY = 2'b01;
   localparam logic [15:0] WDOG_LIMIT  = 16'hFFFF;

   // Index width covers the full NUM_REGS range of 1..256.
   localparam int IDX_W = 8;

endpackage

// File: rtl/axil_regtest_if.sv
// rtl/axil_regtest_if.sv - AXI4-Lite bundle with master and slave views
interface axil_regtest_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_regtest_pattern.sv
// rtl/axil_regtest_pattern.sv - test pattern: rotl(seed, index mod width) xor index
module axil_regtest_pattern
   import axil_regtest_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [DATA_W-1:0] seed,
   input  logic [IDX_W-1:0]  index,
   output logic [DATA_W-1:0] pattern
);
   int unsigned amt;

   // A right shift by the full width yields zero, so amt == 0 needs no special case.
   always_comb begin
      amt     = 32'(index) % DATA_W;
      pattern = ((seed << amt) | (seed >> (DATA_W - amt))) ^ DATA_W'(index);
   end
endmodule

// File: rtl/axil_regtest_master.sv
// rtl/axil_regtest_master.sv - AXI4-Lite register write/read-back test master
// Optional watchdog on handshake waits: define AXIL_REGTEST_TIMEOUT_EN.
module axil_regtest_master
   import axil_regtest_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS           = 4,
   parameter int ERR_WIDTH          = 8
)(
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] seed,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [ERR_WIDTH-1:0]          err_count,
   output logic                          timeout,
   axil_regtest_if.master                m_axi
);
   localparam int               ADDR_SHIFT = (C_M_AXI_DATA_WIDTH == 64) ? 3 : 2;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);

   state_t                        state, state_nxt;
   logic [IDX_W-1:0]              idx;
   logic [C_M_AXI_ADDR_WIDTH-1:0] base_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] seed_q;
   logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
   logic [C_M_AXI_DATA_WIDTH-1:0] pattern;
   logic                          aw_done, w_done;
   logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                          accept, err_inc, timeout_hit, pass_q;

   // One pattern instance serves as write data and, later, as the read-back reference.
   axil_regtest_pattern #(.DATA_W(C_M_AXI_DATA_WIDTH)) u_pattern (
      .seed    (seed_q),
      .index   (idx),
      .pattern (pattern)
   );

   assign addr   = base_q + (C_M_AXI_ADDR_WIDTH'(idx) << ADDR_SHIFT);
   assign accept = (state == IDLE) && start;

   assign m_axi.awaddr  = addr;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = (state == WR) && !aw_done && !timeout_hit;
   assign m_axi.wdata   = pattern;
   assign m_axi.wstrb   = '1;
   assign m_axi.wvalid  = (state == WR) && !w_done && !timeout_hit;
   assign m_axi.bready  = (state == BRESP) && !timeout_hit;
   assign m_axi.araddr  = addr;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = (state == AR) && !timeout_hit;
   assign m_axi.rready  = (state == RDATA) && !timeout_hit;

   assign aw_hs = m_axi.awvalid && m_axi.awready;
   assign w_hs  = m_axi.wvalid && m_axi.wready;
   assign b_hs  = m_axi.bvalid && m_axi.bready;
   assign ar_hs = m_axi.arvalid && m_axi.arready;
   assign r_hs  = m_axi.rvalid && m_axi.rready;

   assign busy = (state != IDLE);
   assign done = (state == FIN);
   assign pass = done ? (err_count == '0) : pass_q;

`ifdef AXIL_REGTEST_TIMEOUT_EN
   logic [15:0] wdog;
   logic        wait_state;
   logic        timeout_q;

   assign wait_state  = state inside {WR, BRESP, AR, RDATA};
   assign timeout_hit = wait_state && (wdog == WDOG_LIMIT);
   assign timeout     = timeout_q;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wdog      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (!wait_state || (state_nxt != state)) wdog <= '0;
         else                                     wdog <= wdog + 16'd1;
         if (accept)           timeout_q <= 1'b0;
         else if (timeout_hit) timeout_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_inc   = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = WR;
         WR:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = BRESP;
         BRESP: if (b_hs) begin
                   state_nxt = AR;
                   err_inc   = (m_axi.bresp != RESP_OKAY);
                end
         AR:    if (ar_hs) state_nxt = RDATA;
         RDATA: if (r_hs) begin
                   state_nxt = CHECK;
                   err_inc   = (m_axi.rresp != RESP_OKAY);
                end
         CHECK: begin
                   state_nxt = NEXT;
                   err_inc   = (rdata_q != pattern);
                end
         NEXT:  state_nxt = (idx == LAST_IDX) ? FIN : WR;
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A stalled handshake abandons the run and counts as one error.
      if (timeout_hit) begin
         state_nxt = FIN;
         err_inc   = 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         idx       <= '0;
         base_q    <= '0;
         seed_q    <= '0;
         rdata_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         err_count <= '0;
         pass_q    <= 1'b0;
      end else begin
         if (accept) begin
            base_q    <= base_addr;
            seed_q    <= seed;
            idx       <= '0;
            err_count <= '0;
            pass_q    <= 1'b0;
         end
         if ((state == NEXT) && (state_nxt == WR)) idx <= idx + 1'b1;
         if ((state == WR) && (state_nxt == WR)) begin
            aw_done <= aw_done || aw_hs;
            w_done  <= w_done || w_hs;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (r_hs) rdata_q <= m_axi.rdata;
         if (err_inc && (err_count != '1)) err_count <= err_count + 1'b1;
         if (state == FIN) pass_q <= (err_count == '0);
      end
   end
endmodule

// File: tb/tb_axil_regtest_master.sv
// tb/tb_axil_regtest_master.sv - randomized bench with AXI4-Lite RAM slave and transaction-level model
module tb_axil_regtest_master;
   localparam int NR = 4;
   localparam int EW = 3;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   base_addr = '0;
   logic [31:0]   seed = '0;
   logic          busy, done, pass, timeout;
   logic [EW-1:0] err_count;

   int n_chk = 0;
   int n_err = 0;

   axil_regtest_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axil_regtest_master #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .NUM_REGS           (NR),
      .ERR_WIDTH          (EW)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .start     (start),
      .base_addr (base_addr),
      .seed      (seed),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .timeout   (timeout),
      .m_axi     (bus)
   );

   always #5 ACLK = ~ACLK;

   // Slave configuration, set by the stimulus before each run.
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   logic [255:0] berr_m, rerr_m;
   logic [31:0] stuck_m [256];
   logic [31:0] mem [256];

   // Slave state
   logic        aw_got, w_got, b_pend, r_pend;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic [31:0] aw_a, w_d, rdata_s, cur_aw, cur_w;
   logic [1:0]  bresp_s, rresp_s;
   logic        aw_hs, w_hs, commit;
   logic [31:0] wa_q[$], wd_q[$], ra_q[$];

   assign bus.awready = bus.awvalid && !aw_got && !b_pend && (aw_cnt >= aw_dly);
   assign bus.wready  = bus.wvalid && !w_got && !b_pend && (w_cnt >= w_dly);
   assign bus.bvalid  = b_pend && (b_cnt >= b_dly);
   assign bus.bresp   = bresp_s;
   assign bus.arready = bus.arvalid && !r_pend && (ar_cnt >= ar_dly);
   assign bus.rvalid  = r_pend && (r_cnt >= r_dly);
   assign bus.rdata   = rdata_s;
   assign bus.rresp   = rresp_s;

   assign aw_hs  = bus.awvalid && bus.awready;
   assign w_hs   = bus.wvalid && bus.wready;
   assign cur_aw = aw_got ? aw_a : bus.awaddr;
   assign cur_w  = w_got ? w_d : bus.wdata;
   assign commit = (aw_got || aw_hs) && (w_got || w_hs);

   always @(posedge ACLK) begin
      if (!ARESETN) begin
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         bresp_s <= 2'b00; rresp_s <= 2'b00; rdata_s <= '0;
      end else begin
         aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
         ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
         b_cnt  <= (b_pend && !bus.bvalid) ? b_cnt + 1 : 0;
         r_cnt  <= (r_pend && !bus.rvalid) ? r_cnt + 1 : 0;
         if (aw_hs) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
         if (w_hs)  begin w_got <= 1'b1;  w_d <= bus.wdata;   end
         if (commit) begin
            mem[cur_aw[9:2]] <= cur_w;
            wa_q.push_back(cur_aw);
            wd_q.push_back(cur_w);
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            b_pend  <= 1'b1;
            bresp_s <= berr_m[cur_aw[9:2]] ? 2'b10 : 2'b00;
         end
         if (bus.bvalid && bus.bready) b_pend <= 1'b0;
         if (bus.arvalid && bus.arready) begin
            ra_q.push_back(bus.araddr);
            r_pend  <= 1'b1;
            rdata_s <= mem[bus.araddr[9:2]] & ~stuck_m[bus.araddr[9:2]];
            rresp_s <= rerr_m[bus.araddr[9:2]] ? 2'b10 : 2'b00;
         end
         if (bus.rvalid && bus.rready) r_pend <= 1'b0;
      end
   end

   // Protocol monitor: VALID held until READY, stable payload, AW/W raised together, fixed PROT/STRB.
   logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [31:0] p_awa, p_wd, p_ara;
   logic        v_aw, v_w, v_ar, v_rise, v_const;
   int          proto_err = 0;

   assign v_aw    = p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awa);
   assign v_w     = p_wv && !p_wr && (!bus.wvalid || bus.wdata != p_wd);
   assign v_ar    = p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_ara);
   assign v_rise  = (bus.awvalid && !p_awv) != (bus.wvalid && !p_wv);
   assign v_const = (bus.awvalid && bus.awprot != 3'b000) || (bus.arvalid && bus.arprot != 3'b000)
                 || (bus.wvalid && bus.wstrb != 4'hF);

   always @(posedge ACLK) begin
      if (!ARESETN) begin
         p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
         p_awr <= 1'b0; p_wr <= 1'b0; p_arr <= 1'b0;
      end else begin
         if (v_aw || v_w || v_ar || v_rise || v_const) proto_err <= proto_err + 1;
         p_awv <= bus.awvalid; p_awr <= bus.awready; p_awa <= bus.awaddr;
         p_wv  <= bus.wvalid;  p_wr  <= bus.wready;  p_wd  <= bus.wdata;
         p_arv <= bus.arvalid; p_arr <= bus.arready; p_ara <= bus.araddr;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_pat(input logic [31:0] s, input int i);
      logic [31:0] r;
      r = s;
      for (int k = 0; k < i % 32; k++) r = {r[30:0], r[31]};
      return r ^ 32'(i);
   endfunction

   task automatic clear_cfg();
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
      berr_m = '0; rerr_m = '0;
      for (int k = 0; k < 256; k++) stuck_m[k] = '0;
   endtask

   task automatic run_test(input string tag, input logic [31:0] b, input logic [31:0] s);
      int          n, exp_err, exp_cyc, proto0;
      logic [31:0] a;
      logic        exp_pass;
      exp_err = 0;
      for (int i = 0; i < NR; i++) begin
         a = b + 32'(i) * 32'd4;
         if (berr_m[a[9:2]]) exp_err++;
         if (rerr_m[a[9:2]]) exp_err++;
         if ((ref_pat(s, i) & stuck_m[a[9:2]]) != 0) exp_err++;
      end
      if (exp_err > (1 << EW) - 1) exp_err = (1 << EW) - 1;
      exp_pass = (exp_err == 0);
      exp_cyc  = NR * (6 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + ar_dly + r_dly);
      wa_q.delete(); wd_q.delete(); ra_q.delete();
      proto0 = proto_err;

      @(negedge ACLK); start = 1'b1; base_addr = b; seed = s;
      @(negedge ACLK); start = 1'b0;
      check_eq({tag, "/busy"}, busy, 1);
      check_eq({tag, "/pass_clr"}, pass, 0);
      n = 0;
      while (!done && n < 2000) begin
         @(negedge ACLK); n++;
         // A start while busy must not restart the run or resample its inputs.
         if (n == 2) begin start = 1'b1; seed = ~s; base_addr = b + 32'h100; end
         else if (n == 3) start = 1'b0;
      end
      check_eq({tag, "/done"}, done, 1);
      check_eq({tag, "/cycles"}, n, exp_cyc);
      check_eq({tag, "/err"}, err_count, exp_err);
      check_eq({tag, "/pass"}, pass, exp_pass);
      check_eq({tag, "/timeout"}, timeout, 0);
      check_eq({tag, "/nwr"}, wa_q.size(), NR);
      check_eq({tag, "/nrd"}, ra_q.size(), NR);
      for (int i = 0; i < NR && i < wa_q.size() && i < ra_q.size(); i++) begin
         a = b + 32'(i) * 32'd4;
         check_eq($sformatf("%s/wa%0d", tag, i), wa_q[i], a);
         check_eq($sformatf("%s/wd%0d", tag, i), wd_q[i], ref_pat(s, i));
         check_eq($sformatf("%s/ra%0d", tag, i), ra_q[i], a);
      end
      @(negedge ACLK);
      check_eq({tag, "/done_pulse"}, done, 0);
      check_eq({tag, "/idle"}, busy, 0);
      check_eq({tag, "/pass_hold"}, pass, exp_pass);
      check_eq({tag, "/proto"}, proto_err - proto0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got no finish expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int          n;
      logic [31:0] b, s, a;
      clear_cfg();
      for (int k = 0; k < 256; k++) mem[k] = '0;

      #1;
      check_eq("rst/outs", {busy, done, pass, timeout, err_count}, '0);
      check_eq("rst/bus", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, '0);
      @(negedge ACLK); @(negedge ACLK); ARESETN = 1'b1;

      run_test("zw", 32'h0, 32'h0101FFFF);
      check_eq("zw/spec_wd1", wd_q[1], 32'h0203FFFF);
      check_eq("zw/spec_wd3", wd_q[3], 32'h080FFFFB);

      clear_cfg(); aw_dly = 3;
      run_test("awdly", 32'h0, 32'h0101FFFF);

      clear_cfg(); stuck_m[1] = 32'h1;
      run_test("stuck", 32'h0, 32'h0101FFFF);

      clear_cfg(); berr_m = '1;
      run_test("slverr", 32'h40, 32'hA5A5_0F0F);

      clear_cfg(); berr_m = '1; rerr_m = '1;
      for (int k = 0; k < 256; k++) stuck_m[k] = 32'hFFFF_FFFF;
      run_test("sat", 32'h80, 32'h1234_5678);

      clear_cfg(); b_dly = 2; r_dly = 1;
      run_test("wrap", 32'hFFFF_FFF8, 32'hDEAD_BEEF);

      // Reset while the read address is outstanding.
      clear_cfg(); ar_dly = 20;
      @(negedge ACLK); start = 1'b1; base_addr = 32'h0; seed = 32'h5555_AAAA;
      @(negedge ACLK); start = 1'b0;
      n = 0;
      while (!bus.arvalid && n < 50) begin @(negedge ACLK); n++; end
      check_eq("rst_ar/arvalid_seen", bus.arvalid, 1);
      #2 ARESETN = 1'b0;
      #1;
      check_eq("rst_ar/arvalid", bus.arvalid, 0);
      check_eq("rst_ar/busy", busy, 0);
      check_eq("rst_ar/err", err_count, 0);
      @(negedge ACLK); @(negedge ACLK); ARESETN = 1'b1;
      clear_cfg();
      run_test("rerun", 32'h10, 32'h5555_AAAA);

      for (int r = 0; r < 8; r++) begin
         clear_cfg();
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
         b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
         r_dly  = $urandom_range(0, 3);
         b = $urandom & 32'hFFFF_FFFC;
         s = $urandom;
         for (int i = 0; i < NR; i++) begin
            a = b + 32'(i) * 32'd4;
            if ($urandom_range(0, 5) == 0) berr_m[a[9:2]] = 1'b1;
            if ($urandom_range(0, 5) == 0) rerr_m[a[9:2]] = 1'b1;
            if ($urandom_range(0, 4) == 0) stuck_m[a[9:2]] = 32'h1 << $urandom_range(0, 31);
         end
         run_test($sformatf("rnd%0d", r), b, s);
      end

`ifdef AXIL_REGTEST_TIMEOUT_EN
      clear_cfg(); ar_dly = 1_000_000;
      @(negedge ACLK); start = 1'b1; base_addr = 32'h0; seed = 32'h0000_1234;
      @(negedge ACLK); start = 1'b0;
      n = 0;
      while (!done && n < 70000) begin @(negedge ACLK); n++; end
      check_eq("to/done", done, 1);
      check_eq("to/timeout", timeout, 1);
      check_eq("to/pass", pass, 0);
      check_eq("to/err", err_count, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
